// File: rtl/huffman_pkg.sv
// Shared definitions for the bit-serial Huffman decoder: table geometry,
// FSM state encoding and code-table entry accessors.
package huffman_pkg;

  localparam int CODE_W  = 13;
  localparam int LEN_MSB = 12;
  localparam int LEN_LSB = 9;
  localparam int MAX_LEN = 9;
  localparam int NUM_SYM = 10;

  typedef enum logic [1:0] {IDLE, RUN, EMIT, ERR} dec_state_e;

  typedef logic [CODE_W-1:0] code_entry_t;

  function automatic logic [3:0] entry_len(input code_entry_t e);
    return e[LEN_MSB:LEN_LSB];
  endfunction

  function automatic logic [MAX_LEN-1:0] entry_code(input code_entry_t e);
    return e[LEN_LSB-1:0];
  endfunction

  // True when a used entry has exactly cnt bits and its low bits equal acc.
  function automatic logic entry_hit(input code_entry_t e,
                                     input logic [MAX_LEN-1:0] acc,
                                     input logic [3:0] cnt);
    logic [MAX_LEN-1:0] mask;
    mask = ~({MAX_LEN{1'b1}} << entry_len(e));
    return (entry_len(e) != 4'd0) && (entry_len(e) == cnt) &&
           ((entry_code(e) & mask) == (acc & mask));
  endfunction

endpackage

// File: rtl/huffman_match.sv
// Combinational code-table matcher: reports whether the accumulated bits form
// a complete codeword and which symbol it is (lowest index wins on overlap).
module huffman_match
  import huffman_pkg::*;
(
  input  logic [MAX_LEN-1:0]             acc,
  input  logic [3:0]                     cnt,
  input  code_entry_t [NUM_SYM-1:0]      tbl,
  output logic                           hit,
  output logic [3:0]                     idx
);

  // Scan from the top down so the lowest matching index is the last written.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (entry_hit(tbl[i], acc, cnt)) begin
        hit = 1'b1;
        idx = 4'(i);
      end
    end
  end

endmodule

// File: rtl/huffman_decode.sv
// Bit-serial Huffman decoder for digits 0-9 with valid/ready symbol output,
// sticky error flag and end-of-decode Fin pulse.
// Optional feature: define HUFF_DEC_COUNT_EN to add the saturating Sym_cnt output.
module huffman_decode
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = 10,
  parameter int MAX_LEN = 9
) (
  input  logic              Clk_in,
  input  logic              n_Rst,
  input  logic              Start_dec,
  input  logic              Stop_dec,
  input  logic [CODE_W-1:0] Code0,
  input  logic [CODE_W-1:0] Code1,
  input  logic [CODE_W-1:0] Code2,
  input  logic [CODE_W-1:0] Code3,
  input  logic [CODE_W-1:0] Code4,
  input  logic [CODE_W-1:0] Code5,
  input  logic [CODE_W-1:0] Code6,
  input  logic [CODE_W-1:0] Code7,
  input  logic [CODE_W-1:0] Code8,
  input  logic [CODE_W-1:0] Code9,
  input  logic              Bit_in,
  input  logic              Bit_valid,
  output logic              Bit_ready,
  output logic [3:0]        Sym_out,
  output logic              Sym_valid,
  input  logic              Sym_ready,
  output logic              Err,
  output logic              Fin
`ifdef HUFF_DEC_COUNT_EN
  ,
  output logic [15:0]       Sym_cnt
`endif
);

  dec_state_e                 state_q, state_n;
  logic [MAX_LEN-1:0]         acc_q, acc_n, acc_shift;
  logic [3:0]                 cnt_q, cnt_n, cnt_inc;
  code_entry_t [NUM_SYM-1:0]  tbl_q, tbl_n;
  logic                       stop_pend_q, stop_pend_n;
  logic                       bit_ready_n, sym_valid_n, err_n, fin_n;
  logic [3:0]                 sym_out_n;
  logic                       hit;
  logic [3:0]                 hit_idx;
  logic                       accept;

  // Candidate accumulator/count as they would be after accepting Bit_in.
  assign acc_shift = {acc_q[MAX_LEN-2:0], Bit_in};
  assign cnt_inc   = cnt_q + 4'd1;
  assign accept    = Bit_valid && Bit_ready;

  huffman_match u_match (
    .acc (acc_shift),
    .cnt (cnt_inc),
    .tbl (tbl_q),
    .hit (hit),
    .idx (hit_idx)
  );

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_n     = state_q;
    acc_n       = acc_q;
    cnt_n       = cnt_q;
    tbl_n       = tbl_q;
    stop_pend_n = stop_pend_q;
    sym_out_n   = Sym_out;
    err_n       = Err;
    fin_n       = 1'b0;

    if (Start_dec) begin
      // Start wins over everything, including a pending symbol or Stop_dec.
      state_n     = RUN;
      tbl_n       = {Code9, Code8, Code7, Code6, Code5, Code4, Code3, Code2, Code1, Code0};
      acc_n       = '0;
      cnt_n       = '0;
      err_n       = 1'b0;
      stop_pend_n = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        RUN: begin
          // A stop that coincided with a bit was parked for one cycle (Bit_ready
          // is low meanwhile) so it sees the updated count.
          if (stop_pend_q || (Stop_dec && !accept)) begin
            fin_n       = 1'b1;
            stop_pend_n = 1'b0;
            if (cnt_q == '0) begin
              state_n = IDLE;
            end else begin
              err_n   = 1'b1;
              state_n = ERR;
            end
          end else if (accept) begin
            acc_n       = acc_shift;
            cnt_n       = cnt_inc;
            stop_pend_n = Stop_dec;
            if (hit) begin
              sym_out_n = hit_idx;
              acc_n     = '0;
              cnt_n     = '0;
              state_n   = EMIT;
            end else if (cnt_inc == 4'(MAX_LEN)) begin
              err_n       = 1'b1;
              fin_n       = 1'b1;
              stop_pend_n = 1'b0;
              state_n     = ERR;
            end
          end
        end
        EMIT: begin
          if (Sym_ready) begin
            if (stop_pend_q || Stop_dec) begin
              fin_n       = 1'b1;
              stop_pend_n = 1'b0;
              state_n     = IDLE;
            end else begin
              state_n = RUN;
            end
          end else begin
            stop_pend_n = stop_pend_q || Stop_dec;
          end
        end
        ERR: ;
        default: state_n = IDLE;
      endcase
    end

    sym_valid_n = (state_n == EMIT);
    bit_ready_n = (state_n == RUN) && !stop_pend_n;
    if (state_n != EMIT) sym_out_n = '0;
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      // NOTE: the table snapshot is reset too, so a decoder never matches against stale entries.
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      tbl_q       <= '0;
      stop_pend_q <= 1'b0;
      Bit_ready   <= 1'b0;
      Sym_out     <= '0;
      Sym_valid   <= 1'b0;
      Err         <= 1'b0;
      Fin         <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q     <= state_n;
      acc_q       <= acc_n;
      cnt_q       <= cnt_n;
      tbl_q       <= tbl_n;
      stop_pend_q <= stop_pend_n;
      Bit_ready   <= bit_ready_n;
      Sym_out     <= sym_out_n;
      Sym_valid   <= sym_valid_n;
      Err         <= err_n;
      Fin         <= fin_n;
    end
  end

`ifdef HUFF_DEC_COUNT_EN
  // Saturating count of symbol handshakes; cleared on restart.
  always_ff @(posedge Clk_in or negedge n_Rst) begin
    if (!n_Rst) begin
      Sym_cnt <= '0;
    end else if (Start_dec) begin
      Sym_cnt <= '0;
    end else if (Sym_valid && Sym_ready && (Sym_cnt != 16'hFFFF)) begin
      Sym_cnt <= Sym_cnt + 16'd1;
    end
  end
`else
  // Symbol counter is not built in this configuration.
`endif

endmodule

// File: tb/tb_huffman_decode.sv
// Self-checking bench for huffman_decode: table-driven single-codeword vectors,
// hand-written corner sequences, and random streams checked against a
// prefix-decoding reference model.
module tb_huffman_decode;

  logic        Clk_in = 1'b0;
  logic        n_Rst, Start_dec, Stop_dec, Bit_in, Bit_valid, Sym_ready;
  logic [12:0] code_in [10];
  logic        Bit_ready, Sym_valid, Err, Fin;
  logic [3:0]  Sym_out;
`ifdef HUFF_DEC_COUNT_EN
  logic [15:0] Sym_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Shared between stream driver and monitor.
  int got_syms [$];
  int fin_cnt;
  bit mon_done;

  // Reference-model state.
  logic [12:0] mtbl [10];
  bit          stim_bits [$];
  int          exp_syms [$];
  bit          exp_err;

  always #5 Clk_in = ~Clk_in;

  huffman_decode dut (
    .Clk_in    (Clk_in),
    .n_Rst     (n_Rst),
    .Start_dec (Start_dec),
    .Stop_dec  (Stop_dec),
    .Code0     (code_in[0]),
    .Code1     (code_in[1]),
    .Code2     (code_in[2]),
    .Code3     (code_in[3]),
    .Code4     (code_in[4]),
    .Code5     (code_in[5]),
    .Code6     (code_in[6]),
    .Code7     (code_in[7]),
    .Code8     (code_in[8]),
    .Code9     (code_in[9]),
    .Bit_in    (Bit_in),
    .Bit_valid (Bit_valid),
    .Bit_ready (Bit_ready),
    .Sym_out   (Sym_out),
    .Sym_valid (Sym_valid),
    .Sym_ready (Sym_ready),
    .Err       (Err),
    .Fin       (Fin)
`ifdef HUFF_DEC_COUNT_EN
    ,
    .Sym_cnt   (Sym_cnt)
`endif
  );

  typedef struct {
    logic [8:0] bits;
    int         nbits;
    logic [3:0] sym;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_in);
    #1;
  endtask

  // Default table: "1"->0, 0111..0001->1..7, 00001->8, 00000->9.
  task automatic set_default_table();
    code_in[0] = {4'd1, 9'd1};
    for (int i = 1; i <= 7; i++) code_in[i] = {4'd4, 9'(8 - i)};
    code_in[8] = {4'd5, 9'd1};
    code_in[9] = {4'd5, 9'd0};
  endtask

  task automatic start();
    Start_dec = 1'b1;
    tick();
    Start_dec = 1'b0;
  endtask

  task automatic pulse_stop();
    Stop_dec = 1'b1;
    tick();
    Stop_dec = 1'b0;
  endtask

  task automatic ack();
    Sym_ready = 1'b1;
    tick();
    Sym_ready = 1'b0;
  endtask

  // Offer one bit and hold it until accepted; gives up on Err or timeout.
  task automatic send_bit(input logic b);
    int budget = 50;
    Bit_in    = b;
    Bit_valid = 1'b1;
    while (!Bit_ready && !Err && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("bit_ready_timeout", Bit_ready, 1);
    if (Bit_ready) tick();
    Bit_valid = 1'b0;
  endtask

  // Reference decoder: grow a prefix bit by bit, emit the lowest-index symbol
  // whose full codeword equals the prefix, error once 9 bits match nothing.
  task automatic model_run();
    int val = 0;
    int n   = 0;
    exp_syms.delete();
    exp_err = 1'b0;
    for (int k = 0; k < stim_bits.size(); k++) begin
      int found = -1;
      val = val * 2 + int'(stim_bits[k]);
      n++;
      for (int s = 0; s < 10; s++) begin
        int len  = int'(mtbl[s][12:9]);
        int code = int'(mtbl[s][8:0]);
        if (found < 0 && len != 0 && len == n && (code % (1 << n)) == val) found = s;
      end
      if (found >= 0) begin
        exp_syms.push_back(found);
        val = 0;
        n   = 0;
      end else if (n == 9) begin
        exp_err = 1'b1;
        break;
      end
    end
    // A stop with a partial codeword outstanding is an error.
    if (!exp_err && n > 0) exp_err = 1'b1;
  endtask

  task automatic run_stream(input int id);
    int nb = $urandom_range(12, 40);
    start();
    for (int s = 0; s < 10; s++) mtbl[s] = code_in[s];
    stim_bits.delete();
    for (int k = 0; k < nb; k++) stim_bits.push_back(1'($urandom_range(0, 1)));
    model_run();
    got_syms.delete();
    fin_cnt  = 0;
    mon_done = 1'b0;
    fork
      begin
        for (int k = 0; k < stim_bits.size(); k++) begin
          if (Err) break;
          repeat ($urandom_range(0, 2)) tick();
          send_bit(stim_bits[k]);
        end
        if (!Err) pulse_stop();
        for (int i = 0; i < 200 && fin_cnt == 0; i++) tick();
        repeat (2) tick();
        mon_done = 1'b1;
      end
      begin
        while (!mon_done) begin
          Sym_ready = ($urandom_range(0, 3) != 0);
          if (Sym_valid && Sym_ready) got_syms.push_back(int'(Sym_out));
          tick();
          if (Fin) fin_cnt++;
        end
        Sym_ready = 1'b0;
      end
    join
    check($sformatf("s%0d_nsyms", id), got_syms.size(), exp_syms.size());
    for (int i = 0; i < got_syms.size() && i < exp_syms.size(); i++)
      check($sformatf("s%0d_sym%0d", id, i), got_syms[i], exp_syms[i]);
    check($sformatf("s%0d_err", id), Err, exp_err);
    check($sformatf("s%0d_fin_count", id), fin_cnt, 1);
  endtask

  initial begin
    n_Rst = 1'b0; Start_dec = 1'b0; Stop_dec = 1'b0;
    Bit_in = 1'b0; Bit_valid = 1'b0; Sym_ready = 1'b0;
    set_default_table();

    vecs[0] = '{9'b1,     1, 4'd0};
    vecs[1] = '{9'b0111,  4, 4'd1};
    vecs[2] = '{9'b00000, 5, 4'd9};
    vecs[3] = '{9'b0110,  4, 4'd2};
    vecs[4] = '{9'b0101,  4, 4'd3};
    vecs[5] = '{9'b0001,  4, 4'd7};
    vecs[6] = '{9'b00001, 5, 4'd8};

    // Reset state.
    #2;
    check("rst_bit_ready", Bit_ready, 0);
    check("rst_sym_valid", Sym_valid, 0);
    check("rst_sym_out",   Sym_out,   0);
    check("rst_err",       Err,       0);
    check("rst_fin",       Fin,       0);
    #20 n_Rst = 1'b1;
    tick();
    check("idle_bit_ready", Bit_ready, 0);

    // Start -> Bit_ready the next cycle.
    start();
    check("start_bit_ready", Bit_ready, 1);
    check("start_sym_valid", Sym_valid, 0);

    // Single-codeword vectors, back to back.
    for (int v = 0; v < 7; v++) begin
      for (int k = vecs[v].nbits - 1; k >= 0; k--) begin
        send_bit(vecs[v].bits[k]);
        if (k > 0) check($sformatf("v%0d_early_valid", v), Sym_valid, 0);
      end
      check($sformatf("v%0d_valid", v), Sym_valid, 1);
      check($sformatf("v%0d_sym", v), Sym_out, vecs[v].sym);
      check($sformatf("v%0d_fin", v), Fin, 0);
      check($sformatf("v%0d_bit_ready_emit", v), Bit_ready, 0);
      ack();
      check($sformatf("v%0d_resume", v), Bit_ready, 1);
    end

    // Backpressure: symbol held stable while Sym_ready is low.
    for (int k = 3; k >= 0; k--) send_bit(k == 3 ? 1'b0 : 1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d_sym", c), Sym_out, 1);
      check($sformatf("bp%0d_valid", c), Sym_valid, 1);
      check($sformatf("bp%0d_bit_ready", c), Bit_ready, 0);
      tick();
    end
    ack();
    check("bp_resume", Bit_ready, 1);
    check("bp_valid_drop", Sym_valid, 0);

    // Stop deferred during EMIT, honoured at the handshake.
    send_bit(1'b1);
    pulse_stop();
    check("emit_stop_fin_wait", Fin, 0);
    check("emit_stop_hold", Sym_valid, 1);
    ack();
    check("emit_stop_fin", Fin, 1);
    check("emit_stop_err", Err, 0);
    check("emit_stop_idle", Bit_ready, 0);

    // Malformed stream: Code8/9 unused, nine zeros.
    code_in[8] = '0;
    code_in[9] = '0;
    start();
    set_default_table();
    for (int k = 0; k < 8; k++) send_bit(1'b0);
    check("miss8_err", Err, 0);
    send_bit(1'b0);
    check("miss9_err", Err, 1);
    check("miss9_fin", Fin, 1);
    tick();
    check("miss_fin_pulse", Fin, 0);
    repeat (3) tick();
    check("err_held", Err, 1);
    check("err_bit_ready", Bit_ready, 0);
    start();
    check("err_restart_err", Err, 0);
    check("err_restart_ready", Bit_ready, 1);

    // Stop with a partial codeword.
    send_bit(1'b0);
    send_bit(1'b1);
    pulse_stop();
    check("stop_partial_err", Err, 1);
    check("stop_partial_fin", Fin, 1);
    tick();
    check("stop_partial_fin_pulse", Fin, 0);

    // Stop with nothing outstanding.
    start();
    pulse_stop();
    check("stop_clean_fin", Fin, 1);
    check("stop_clean_err", Err, 0);
    check("stop_clean_idle", Bit_ready, 0);
    tick();
    check("stop_clean_fin_pulse", Fin, 0);

    // Bit and Stop in the same cycle: bit counted, stop judged next cycle.
    start();
    send_bit(1'b0);
    Bit_in = 1'b1; Bit_valid = 1'b1; Stop_dec = 1'b1;
    tick();
    Bit_valid = 1'b0; Stop_dec = 1'b0;
    check("bitstop_ready_low", Bit_ready, 0);
    check("bitstop_fin_late", Fin, 0);
    tick();
    check("bitstop_fin", Fin, 1);
    check("bitstop_err", Err, 1);

    // Table snapshot: later table changes are ignored.
    start();
    code_in[0] = {4'd1, 9'd0};
    code_in[9] = {4'd5, 9'd31};
    send_bit(1'b1);
    check("snap_sym0", Sym_out, 0);
    check("snap_valid0", Sym_valid, 1);
    ack();
    for (int k = 0; k < 5; k++) send_bit(1'b0);
    check("snap_sym9", Sym_out, 9);
    ack();
    set_default_table();

    // Reset mid-code.
    send_bit(1'b0);
    send_bit(1'b1);
    #2 n_Rst = 1'b0;
    #1;
    check("midrst_bit_ready", Bit_ready, 0);
    check("midrst_err", Err, 0);
    check("midrst_fin", Fin, 0);
    check("midrst_valid", Sym_valid, 0);
    tick();
    n_Rst = 1'b1;
    tick();
    check("midrst_fin_after", Fin, 0);
    check("midrst_idle", Bit_ready, 0);

`ifdef HUFF_DEC_COUNT_EN
    start();
    for (int s = 0; s < 5; s++) begin
      send_bit(1'b1);
      ack();
    end
    check("cnt_five", Sym_cnt, 5);
    start();
    check("cnt_cleared", Sym_cnt, 0);
`endif

    // Random streams on the full table and on a sparse table.
    for (int t = 0; t < 2; t++) begin
      set_default_table();
      if (t == 1) for (int i = 1; i <= 7; i++) code_in[i] = '0;
      for (int s = 0; s < 6; s++) run_stream(t * 10 + s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
